// File: rtl/fixed_point_params_pkg.sv
// Fixed-point constants, gate opcodes, FSM states and the saturation helper
// shared by the qubit-gate datapath blocks.
package fixed_point_params;

   localparam int TOTAL_WIDTH  = 8;
   localparam int FP_FRAC      = 4;
   localparam int FP_INV_SQRT2 = 11;

   typedef enum logic [2:0] {
      GATE_I   = 3'd0,
      GATE_X   = 3'd1,
      GATE_Z   = 3'd2,
      GATE_H   = 3'd3,
      GATE_S   = 3'd4,
      GATE_T   = 3'd5,
      GATE_SDG = 3'd6,
      GATE_ILL = 3'd7
   } gate_e;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_LOAD    = 2'd1,
      ST_COMPUTE = 2'd2,
      ST_UNLOAD  = 2'd3
   } state_e;

   // Clamp a wide signed value into the range of a w-bit two's complement number.
   function automatic logic signed [63:0] saturate(input logic signed [63:0] x, input int w);
      logic signed [63:0] hi;
      logic signed [63:0] lo;
      hi = (64'sd1 <<< (w - 1)) - 64'sd1;
      lo = -(64'sd1 <<< (w - 1));
      if (x > hi) return hi;
      if (x < lo) return lo;
      return x;
   endfunction

endpackage

// File: rtl/qgate_stream_engine_butterfly.sv
// Combinational single-qubit gate on one amplitude pair: W+1-bit sums,
// full-width products, floor shift by FRAC, saturation on every result.
module qgate_butterfly #(
   parameter int W         = fixed_point_params::TOTAL_WIDTH,
   parameter int FRAC      = fixed_point_params::FP_FRAC,
   parameter int INV_SQRT2 = fixed_point_params::FP_INV_SQRT2
) (
   input  logic        [2:0]   gate,
   input  logic signed [W-1:0] a0_r,
   input  logic signed [W-1:0] a0_i,
   input  logic signed [W-1:0] a1_r,
   input  logic signed [W-1:0] a1_i,
   output logic signed [W-1:0] y0_r,
   output logic signed [W-1:0] y0_i,
   output logic signed [W-1:0] y1_r,
   output logic signed [W-1:0] y1_i
);
   import fixed_point_params::*;

   typedef logic signed [63:0] wide_t;

   function automatic logic signed [W-1:0] fit(input wide_t x);
      wide_t s;
      s = saturate(x, W);
      return s[W-1:0];
   endfunction

   function automatic wide_t scale(input logic signed [W:0] s);
      return (wide_t'(s) * wide_t'(INV_SQRT2)) >>> FRAC;
   endfunction

   logic signed [W:0] add_r, add_i, sub_r, sub_i, t_dif, t_sum;

   assign add_r = (W+1)'(a0_r) + (W+1)'(a1_r);
   assign add_i = (W+1)'(a0_i) + (W+1)'(a1_i);
   assign sub_r = (W+1)'(a0_r) - (W+1)'(a1_r);
   assign sub_i = (W+1)'(a0_i) - (W+1)'(a1_i);
   assign t_dif = (W+1)'(a1_r) - (W+1)'(a1_i);
   assign t_sum = (W+1)'(a1_r) + (W+1)'(a1_i);

   always_comb begin
      y0_r = a0_r;
      y0_i = a0_i;
      y1_r = a1_r;
      y1_i = a1_i;
      case (gate_e'(gate))
         GATE_X: begin
            y0_r = a1_r;
            y0_i = a1_i;
            y1_r = a0_r;
            y1_i = a0_i;
         end
         GATE_Z: begin
            y1_r = fit(-wide_t'(a1_r));
            y1_i = fit(-wide_t'(a1_i));
         end
         GATE_H: begin
            y0_r = fit(scale(add_r));
            y0_i = fit(scale(add_i));
            y1_r = fit(scale(sub_r));
            y1_i = fit(scale(sub_i));
         end
         GATE_S: begin
            y1_r = fit(-wide_t'(a1_i));
            y1_i = a1_r;
         end
         GATE_T: begin
            y1_r = fit(scale(t_dif));
            y1_i = fit(scale(t_sum));
         end
         GATE_SDG: begin
            y1_r = a1_i;
            y1_i = fit(-wide_t'(a1_r));
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/qgate_stream_engine.sv
// Serial state-vector gate engine: load 2^NQ amplitudes, apply one optionally
// controlled gate pair-by-pair in place, stream out in natural or bit-reversed order.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_IDLE    | cfg_ready high; legal cfg latches and starts a load
// ST_LOAD    | in_ready high; accepts amplitudes 0 .. 2^NQ-1
// ST_COMPUTE | one amplitude pair per cycle through the butterfly
// ST_UNLOAD  | streams the buffer out; returns to idle after out_last
module qgate_stream_engine #(
   parameter int  NQ        = 3,
   parameter int  W         = fixed_point_params::TOTAL_WIDTH,
   parameter int  FRAC      = fixed_point_params::FP_FRAC,
   parameter int  INV_SQRT2 = fixed_point_params::FP_INV_SQRT2,
   localparam int CW        = ($clog2(NQ) > 1) ? $clog2(NQ) : 1
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                cfg_valid,
   output logic                cfg_ready,
   input  logic        [2:0]   cfg_gate,
   input  logic        [CW-1:0] cfg_target,
   input  logic        [CW-1:0] cfg_ctrl,
   input  logic                cfg_ctrl_en,
   input  logic                cfg_bitrev,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic signed [W-1:0] in_r,
   input  logic signed [W-1:0] in_i,
   output logic                out_valid,
   input  logic                out_ready,
   output logic signed [W-1:0] out_r,
   output logic signed [W-1:0] out_i,
   output logic        [NQ-1:0] out_idx,
   output logic                out_last,
   output logic                busy,
   output logic                err
);
   import fixed_point_params::*;

   localparam int N  = 1 << NQ;
   localparam int NP = N / 2;

   state_e state, state_nxt;

   logic [2:0]    gate_q;
   logic [CW-1:0] tgt_q, ctl_q;
   logic          ctl_en_q, bitrev_q;
   logic [NQ-1:0] wr_idx, k_cnt, rd_addr;
   logic [NQ-2:0] pair;

   logic signed [W-1:0] buf_r [N];
   logic signed [W-1:0] buf_i [N];

   logic cfg_fire, cfg_legal, in_fire, out_fire;

   assign cfg_ready = (state == ST_IDLE);
   assign in_ready  = (state == ST_LOAD);
   assign busy      = (state != ST_IDLE);
   assign cfg_fire  = cfg_valid && cfg_ready;
   assign in_fire   = in_valid && in_ready;
   assign out_fire  = out_valid && out_ready;

   assign cfg_legal = (cfg_gate != GATE_ILL) && (int'(cfg_target) < NQ) &&
                      (!cfg_ctrl_en || ((int'(cfg_ctrl) < NQ) && (cfg_ctrl != cfg_target)));

   // Pair addresses: a zero bit is spliced into the pair counter at the target position.
   logic [NQ-1:0] p_ext, lo_mask, i0, i1;
   logic          pair_active;

   always_comb begin
      p_ext       = {1'b0, pair};
      lo_mask     = (NQ'(1) << tgt_q) - NQ'(1);
      i0          = ((p_ext >> tgt_q) << (int'(tgt_q) + 1)) | (p_ext & lo_mask);
      i1          = i0 | (NQ'(1) << tgt_q);
      pair_active = !ctl_en_q || i0[ctl_q];
   end

   logic        [2:0]   bf_gate;
   logic signed [W-1:0] y0_r, y0_i, y1_r, y1_i;

   assign bf_gate = pair_active ? gate_q : GATE_I;

   qgate_butterfly #(.W(W), .FRAC(FRAC), .INV_SQRT2(INV_SQRT2)) u_butterfly (
      .gate (bf_gate),
      .a0_r (buf_r[i0]),
      .a0_i (buf_i[i0]),
      .a1_r (buf_r[i1]),
      .a1_i (buf_i[i1]),
      .y0_r (y0_r),
      .y0_i (y0_i),
      .y1_r (y1_r),
      .y1_i (y1_i)
   );

   always_comb begin
      rd_addr = k_cnt;
      if (bitrev_q) begin
         for (int b = 0; b < NQ; b++) rd_addr[b] = k_cnt[NQ-1-b];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:    if (cfg_fire && cfg_legal)                  state_nxt = ST_LOAD;
         ST_LOAD:    if (in_fire && (wr_idx == NQ'(N - 1)))      state_nxt = ST_COMPUTE;
         ST_COMPUTE: if (pair == (NQ-1)'(NP - 1))                state_nxt = ST_UNLOAD;
         ST_UNLOAD:  if (out_fire && out_last)                   state_nxt = ST_IDLE;
         default:                                                state_nxt = ST_IDLE;
      endcase
   end

   // Buffer contents are don't-care after reset, so the array carries no reset.
   always_ff @(posedge clk) begin
      if (in_fire) begin
         buf_r[wr_idx] <= in_r;
         buf_i[wr_idx] <= in_i;
      end
      if (state == ST_COMPUTE) begin
         buf_r[i0] <= y0_r;
         buf_i[i0] <= y0_i;
         buf_r[i1] <= y1_r;
         buf_i[i1] <= y1_i;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         gate_q    <= '0;
         tgt_q     <= '0;
         ctl_q     <= '0;
         ctl_en_q  <= 1'b0;
         bitrev_q  <= 1'b0;
         wr_idx    <= '0;
         pair      <= '0;
         k_cnt     <= '0;
         err       <= 1'b0;
         out_valid <= 1'b0;
         out_last  <= 1'b0;
         out_r     <= '0;
         out_i     <= '0;
         out_idx   <= '0;
      end else begin
         err <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (cfg_fire) begin
                  if (cfg_legal) begin
                     gate_q   <= cfg_gate;
                     tgt_q    <= cfg_target;
                     ctl_q    <= cfg_ctrl;
                     ctl_en_q <= cfg_ctrl_en;
                     bitrev_q <= cfg_bitrev;
                     wr_idx   <= '0;
                     pair     <= '0;
                  end else begin
                     err <= 1'b1;
                  end
               end
            end
            ST_LOAD: if (in_fire) wr_idx <= wr_idx + NQ'(1);
            ST_COMPUTE: begin
               pair  <= pair + (NQ-1)'(1);
               k_cnt <= '0;
            end
            ST_UNLOAD: begin
               if (out_fire && out_last) begin
                  out_valid <= 1'b0;
                  out_last  <= 1'b0;
               end else if (!out_valid || out_ready) begin
                  out_valid <= 1'b1;
                  out_r     <= buf_r[rd_addr];
                  out_i     <= buf_i[rd_addr];
                  out_idx   <= k_cnt;
                  out_last  <= (k_cnt == NQ'(N - 1));
                  k_cnt     <= k_cnt + NQ'(1);
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_qgate_stream_engine.sv
// Self-checking bench for qgate_stream_engine (NQ=3, W=8): directed vectors from
// the test plan plus randomized gates/data against an arithmetic reference model.
module tb_qgate_stream_engine;

   localparam int NQ = 3;
   localparam int N  = 8;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              cfg_valid = 1'b0;
   logic              cfg_ready;
   logic [2:0]        cfg_gate = '0;
   logic [1:0]        cfg_target = '0;
   logic [1:0]        cfg_ctrl = '0;
   logic              cfg_ctrl_en = 1'b0;
   logic              cfg_bitrev = 1'b0;
   logic              in_valid = 1'b0;
   logic              in_ready;
   logic signed [7:0] in_r = '0;
   logic signed [7:0] in_i = '0;
   logic              out_valid;
   logic              out_ready = 1'b0;
   logic signed [7:0] out_r;
   logic signed [7:0] out_i;
   logic [2:0]        out_idx;
   logic              out_last;
   logic              busy;
   logic              err;

   qgate_stream_engine #(.NQ(NQ)) dut (
      .clk(clk), .rst_n(rst_n),
      .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_gate(cfg_gate),
      .cfg_target(cfg_target), .cfg_ctrl(cfg_ctrl), .cfg_ctrl_en(cfg_ctrl_en),
      .cfg_bitrev(cfg_bitrev),
      .in_valid(in_valid), .in_ready(in_ready), .in_r(in_r), .in_i(in_i),
      .out_valid(out_valid), .out_ready(out_ready), .out_r(out_r), .out_i(out_i),
      .out_idx(out_idx), .out_last(out_last), .busy(busy), .err(err)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   int vec_r [N], vec_i [N];
   int res_r [N], res_i [N];
   int exp_r [N], exp_i [N];
   int got_r [N], got_i [N];
   int got_beat_r [N];
   int exp_k = 0;
   bit unl_active = 1'b0;
   int ready_mode = 0;

   task automatic check(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, req);
      end
   endtask

   function automatic int sat(input int x);
      return (x > 127) ? 127 : ((x < -128) ? -128 : x);
   endfunction

   // floor(x * 11 / 16) written as explicit floor division
   function automatic int scl(input int x);
      int q;
      q = x * 11;
      if (q >= 0) return q / 16;
      return -((-q + 15) / 16);
   endfunction

   function automatic int rev3(input int k);
      return ((k & 1) << 2) | (k & 2) | ((k >> 2) & 1);
   endfunction

   task automatic model(input int g, input int t, input int c, input bit en, input bit br);
      int j, r0, i0, r1, i1;
      for (int k = 0; k < N; k++) begin
         res_r[k] = vec_r[k];
         res_i[k] = vec_i[k];
      end
      for (int idx = 0; idx < N; idx++) begin
         if (((idx >> t) & 1) != 0) continue;
         if (en && (((idx >> c) & 1) == 0)) continue;
         j  = idx + (1 << t);
         r0 = vec_r[idx]; i0 = vec_i[idx]; r1 = vec_r[j]; i1 = vec_i[j];
         case (g)
            1: begin res_r[idx] = r1; res_i[idx] = i1; res_r[j] = r0; res_i[j] = i0; end
            2: begin res_r[j] = sat(-r1); res_i[j] = sat(-i1); end
            3: begin
               res_r[idx] = sat(scl(r0 + r1)); res_i[idx] = sat(scl(i0 + i1));
               res_r[j]   = sat(scl(r0 - r1)); res_i[j]   = sat(scl(i0 - i1));
            end
            4: begin res_r[j] = sat(-i1); res_i[j] = r1; end
            5: begin res_r[j] = sat(scl(r1 - i1)); res_i[j] = sat(scl(r1 + i1)); end
            6: begin res_r[j] = i1; res_i[j] = sat(-r1); end
            default: ;
         endcase
      end
      for (int k = 0; k < N; k++) begin
         exp_r[k] = res_r[br ? rev3(k) : k];
         exp_i[k] = res_i[br ? rev3(k) : k];
      end
   endtask

   // Compare process: every negedge, any valid output must match the model beat.
   always @(negedge clk) begin
      if (rst_n) begin
         if (unl_active) begin
            if (out_valid && exp_k < N) begin
               check("out_r", out_r, exp_r[exp_k]);
               check("out_i", out_i, exp_i[exp_k]);
               check("out_idx", out_idx, exp_k);
               check("out_last", out_last, (exp_k == N - 1) ? 1 : 0);
               got_beat_r[exp_k] = out_r;
               got_r[cfg_bitrev ? rev3(exp_k) : exp_k] = out_r;
               got_i[cfg_bitrev ? rev3(exp_k) : exp_k] = out_i;
            end
            case (ready_mode)
               0: out_ready = 1'($urandom_range(0, 1));
               1: out_ready = ~out_ready;
               default: out_ready = 1'b1;
            endcase
            if (out_valid && out_ready && exp_k < N) exp_k++;
         end else begin
            check("out_valid_idle", out_valid, 0);
            out_ready = 1'($urandom_range(0, 1));
         end
      end
   end

   task automatic send_cfg(input int g, input int t, input int c, input bit en, input bit br,
                           input bit legal);
      @(negedge clk);
      check("cfg_ready_before_cfg", cfg_ready, 1);
      cfg_valid = 1'b1; cfg_gate = 3'(g); cfg_target = 2'(t); cfg_ctrl = 2'(c);
      cfg_ctrl_en = en; cfg_bitrev = br;
      @(posedge clk); #1;
      cfg_valid = 1'b0;
      if (legal) begin
         check("busy_after_cfg", busy, 1);
         check("in_ready_after_cfg", in_ready, 1);
      end else begin
         check("err_pulse", err, 1);
         check("busy_illegal", busy, 0);
         check("in_ready_illegal", in_ready, 0);
         @(posedge clk); #1;
         check("err_one_cycle", err, 0);
      end
   endtask

   task automatic run_vec(input int g, input int t, input int c, input bit en, input bit br,
                          input int mode, input bit gaps);
      int accepted, lat, n;
      bit acc;
      model(g, t, c, en, br);
      send_cfg(g, t, c, en, br, 1'b1);
      ready_mode = mode;
      accepted = 0;
      for (n = 0; n < 200 && accepted < N; n++) begin
         @(negedge clk);
         in_valid = gaps ? 1'($urandom_range(0, 3) != 0) : 1'b1;
         in_r = 8'(vec_r[accepted]);
         in_i = 8'(vec_i[accepted]);
         acc = in_valid && in_ready;
         @(posedge clk); #1;
         if (acc) accepted++;
      end
      in_valid = 1'b0;
      check("load_done", accepted, N);
      exp_k = 0;
      out_ready = (mode == 1);
      unl_active = 1'b1;
      for (lat = 1; lat <= 20; lat++) begin
         @(posedge clk); #1;
         if (out_valid) break;
      end
      check("latency", lat, 5);
      for (n = 0; n < 400 && exp_k < N; n++) begin
         @(posedge clk); #1;
      end
      if (exp_k == N) begin
         @(posedge clk); #1;
      end
      check("beats", exp_k, N);
      check("cfg_ready_after_last", cfg_ready, 1);
      check("busy_after_last", busy, 0);
      unl_active = 1'b0;
   endtask

   task automatic clear_vec();
      for (int k = 0; k < N; k++) begin vec_r[k] = 0; vec_i[k] = 0; end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin
      #1;
      check("rst_cfg_ready", cfg_ready, 1);
      check("rst_in_ready", in_ready, 0);
      check("rst_out_valid", out_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_err", err, 0);
      check("rst_out_last", out_last, 0);
      check("rst_out_r", out_r, 0);
      check("rst_out_idx", out_idx, 0);
      #24 rst_n = 1'b1;

      clear_vec(); vec_r[6] = 16;
      run_vec(3, 0, 0, 0, 0, 2, 0);
      check("h_f110", got_r[6], 11);
      check("h_f111", got_r[7], 11);
      check("h_f000", got_r[0], 0);

      clear_vec(); vec_r[0] = 8; vec_r[4] = 16;
      run_vec(1, 0, 2, 1, 0, 0, 1);
      check("cx_a000", got_r[0], 8);
      check("cx_a101", got_r[5], 16);
      check("cx_a100", got_r[4], 0);

      clear_vec(); vec_r[2] = 16;
      run_vec(5, 1, 0, 0, 0, 0, 0);
      check("t_a010_r", got_r[2], 11);
      check("t_a010_i", got_i[2], 11);

      clear_vec(); vec_r[1] = 5; vec_i[1] = -3;
      run_vec(4, 0, 0, 0, 0, 2, 0);
      check("s_a001_r", got_r[1], 3);
      check("s_a001_i", got_i[1], 5);

      clear_vec();
      for (int k = 0; k < N; k++) vec_r[k] = k;
      run_vec(0, 0, 0, 0, 1, 1, 0);
      check("bitrev_beat1", got_beat_r[1], 4);
      check("bitrev_beat3", got_beat_r[3], 6);
      check("bitrev_beat6", got_beat_r[6], 3);

      clear_vec(); vec_r[0] = 127; vec_r[1] = 127;
      run_vec(3, 0, 0, 0, 0, 0, 0);
      check("hsat_a0", got_r[0], 127);
      check("hsat_a1", got_r[1], 0);

      clear_vec(); vec_r[1] = -128;
      run_vec(2, 0, 0, 0, 0, 0, 0);
      check("zsat_a1", got_r[1], 127);

      send_cfg(3, 1, 1, 1, 0, 1'b0);
      send_cfg(7, 0, 1, 0, 0, 1'b0);
      send_cfg(0, 3, 0, 0, 0, 1'b0);

      @(negedge clk);
      in_valid = 1'b1;
      @(negedge clk);
      check("in_ready_in_idle", in_ready, 0);
      check("busy_in_idle", busy, 0);
      in_valid = 1'b0;

      for (int r = 0; r < 12; r++) begin
         int g, t, c;
         bit en;
         g = $urandom_range(0, 6);
         t = $urandom_range(0, 2);
         c = (t + $urandom_range(1, 2)) % 3;
         en = 1'($urandom_range(0, 1));
         for (int k = 0; k < N; k++) begin
            vec_r[k] = $urandom_range(0, 255) - 128;
            vec_i[k] = $urandom_range(0, 255) - 128;
         end
         run_vec(g, t, c, en, 1'($urandom_range(0, 1)), $urandom_range(0, 2), 1'($urandom_range(0, 1)));
      end

      send_cfg(3, 0, 0, 0, 0, 1'b1);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         in_valid = 1'b1; in_r = 8'(k + 1); in_i = '0;
      end
      @(negedge clk);
      in_valid = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      check("mid_rst_cfg_ready", cfg_ready, 1);
      check("mid_rst_in_ready", in_ready, 0);
      check("mid_rst_busy", busy, 0);
      check("mid_rst_out_valid", out_valid, 0);
      check("mid_rst_err", err, 0);
      check("mid_rst_out_r", out_r, 0);
      @(negedge clk);
      rst_n = 1'b1;

      clear_vec(); vec_r[3] = 40; vec_i[3] = -20;
      run_vec(6, 1, 0, 1, 0, 0, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
